// File: rtl/p_mul.sv
// p_mul -- sequential packed unsigned multiplier, 32-bit operands.
//
// Multiplies every lane of lhs by the matching lane of rhs for lane widths
// 32/16/8/4/2 using one shift-and-add step per multiplier bit. Each lane keeps
// its own 2w-bit slot in a 64-bit accumulator, so carries never cross lanes.
// The low or high w bits of every slot are packed back into lane positions.
//
// Optional feature macro: P_MUL_CLMUL_EN
//   defined   : clmul=1 accumulates with XOR (carry-less per-lane product)
//   undefined : clmul is ignored, integer products only
//
// Ports:
//   g_clk    in   1   clock, rising edge
//   g_reset  in   1   synchronous active-high reset
//   valid    in   1   request, held with stable operands until ready
//   lhs      in  32   multiplicand lanes
//   rhs      in  32   multiplier lanes
//   pw       in   5   one-hot lane width (bit0=32 .. bit4=2), lowest set bit wins
//   high     in   1   1: upper half of each lane product, 0: lower half
//   clmul    in   1   carry-less mode select (only with P_MUL_CLMUL_EN)
//   ready    out  1   one-cycle completion pulse
//   result   out 32   registered packed result
module p_mul (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        high,
    input  logic        clmul,
    output logic        ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] acc;       // per-lane 2w-bit product slots
    logic [4:0]  cnt;       // current multiplier bit index j
    logic [2:0]  sel;       // latched width index: w = 32 >> sel

    logic [2:0]  pw_sel;
    logic        pw_zero;
    logic [4:0]  last_cnt;
    logic        last_step;
    logic [63:0] sum_sel;
    logic [31:0] res_sel;

`ifndef P_MUL_CLMUL_EN
    logic unused_clmul;
    assign unused_clmul = clmul;
`endif

    // Width decode: lowest set bit of pw selects the lane width.
    always_comb begin
        pw_zero = (pw == '0);
        pw_sel  = 3'd0;
        if (pw[0])      pw_sel = 3'd0;
        else if (pw[1]) pw_sel = 3'd1;
        else if (pw[2]) pw_sel = 3'd2;
        else if (pw[3]) pw_sel = 3'd3;
        else if (pw[4]) pw_sel = 3'd4;
    end

    always_comb begin
        last_cnt = 5'd31;
        case (sel)
            3'd0:    last_cnt = 5'd31;
            3'd1:    last_cnt = 5'd15;
            3'd2:    last_cnt = 5'd7;
            3'd3:    last_cnt = 5'd3;
            3'd4:    last_cnt = 5'd1;
            default: last_cnt = 5'd31;
        endcase
    end

    assign last_step = (cnt == last_cnt);

    // One accumulate step per width, built from constant lane slices. The
    // partial product of lane i is its zero-extended lhs lane shifted by j,
    // gated by bit j of the rhs lane; each slot sums independently.
    for (genvar k = 0; k < 5; k++) begin : g_width
        localparam int unsigned W  = 32 >> k;
        localparam int unsigned LB = $clog2(W);

        logic [63:0] sum;
        logic [31:0] res;

        for (genvar i = 0; i < 32 / W; i++) begin : g_lane
            logic [W-1:0]   a_lane;
            logic [W-1:0]   b_lane;
            logic [2*W-1:0] acc_slot;
            logic [2*W-1:0] pp;
            logic [2*W-1:0] slot_sum;

            assign a_lane   = lhs[W*i +: W];
            assign b_lane   = rhs[W*i +: W];
            assign acc_slot = acc[2*W*i +: 2*W];
            assign pp       = b_lane[cnt[LB-1:0]] ? ({{W{1'b0}}, a_lane} << cnt) : '0;

`ifdef P_MUL_CLMUL_EN
            assign slot_sum = clmul ? (acc_slot ^ pp) : (acc_slot + pp);
`else
            assign slot_sum = acc_slot + pp;
`endif

            assign sum[2*W*i +: 2*W] = slot_sum;
            assign res[W*i +: W]     = high ? slot_sum[2*W-1:W] : slot_sum[W-1:0];
        end
    end

    always_comb begin
        sum_sel = g_width[0].sum;
        res_sel = g_width[0].res;
        case (sel)
            3'd1: begin
                sum_sel = g_width[1].sum;
                res_sel = g_width[1].res;
            end
            3'd2: begin
                sum_sel = g_width[2].sum;
                res_sel = g_width[2].res;
            end
            3'd3: begin
                sum_sel = g_width[3].sum;
                res_sel = g_width[3].res;
            end
            3'd4: begin
                sum_sel = g_width[4].sum;
                res_sel = g_width[4].res;
            end
            default: begin
                sum_sel = g_width[0].sum;
                res_sel = g_width[0].res;
            end
        endcase
    end

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt = pw_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the pulse coincides with the DONE state.
    always_comb begin
        ready = (state == DONE);
    end

    // Datapath. The final step registers the packed result straight from the
    // last accumulate so that it is already valid in the DONE cycle.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            acc    <= '0;
            cnt    <= '0;
            sel    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        acc <= '0;
                        cnt <= '0;
                        sel <= pw_sel;
                        if (pw_zero) begin
                            result <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (valid) begin
                        acc <= sum_sel;
                        cnt <= cnt + 5'd1;
                        if (last_step) begin
                            result <= res_sel;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p_mul.sv
module tb_p_mul;

    logic        g_clk;
    logic        g_reset;
    logic        valid;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  pw;
    logic        high;
    logic        clmul;
    logic        ready;
    logic [31:0] result;

    p_mul dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .valid   (valid),
        .lhs     (lhs),
        .rhs     (rhs),
        .pw      (pw),
        .high    (high),
        .clmul   (clmul),
        .ready   (ready),
        .result  (result)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    int unsigned cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;

    // Expectation state: cur_res holds the settled result; from cycle
    // pend_cyc onward the result becomes pend_res, and ready is expected
    // exactly in cycle pend_cyc when pend_rdy is set.
    logic        chk_en   = 1'b0;
    logic [31:0] cur_res  = '0;
    logic [31:0] pend_res = '0;
    int unsigned pend_cyc = NEVER;
    logic        pend_rdy = 1'b0;

    function automatic int unsigned width_of(input logic [4:0] p);
        int unsigned w;
        w = 0;
        for (int k = 4; k >= 0; k--) begin
            if (p[k]) w = 32 >> k;
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [4:0] p, input logic [31:0] a,
                                            input logic [31:0] b, input logic hi,
                                            input logic cl);
        int unsigned     w;
        longint unsigned mask, x, y, prod, part;
        logic [31:0]     res;
        w   = width_of(p);
        res = '0;
        if (w == 0) return res;
        mask = (64'd1 << w) - 64'd1;
        for (int unsigned i = 0; i < 32 / w; i++) begin
            x = (longint'(a) >> (w * i)) & mask;
            y = (longint'(b) >> (w * i)) & mask;
            if (cl) begin
                prod = 0;
                for (int unsigned t = 0; t < w; t++) begin
                    if (((y >> t) & 64'd1) != 0) prod = prod ^ (x << t);
                end
            end else begin
                prod = x * y;
            end
            part = hi ? ((prod >> w) & mask) : (prod & mask);
            res  = res | 32'(part << (w * i));
        end
        return res;
    endfunction

    always @(negedge g_clk) begin
        logic        exp_rdy;
        logic [31:0] exp_res;
        if (chk_en) begin
            exp_rdy = pend_rdy && (cyc == pend_cyc);
            exp_res = (cyc >= pend_cyc) ? pend_res : cur_res;
            checks++;
            if (ready !== exp_rdy) begin
                errors++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, exp_rdy);
            end
            checks++;
            if (result !== exp_res) begin
                errors++;
                $display("FAIL result cyc=%0d got=%h exp=%h", cyc, result, exp_res);
            end
        end
    end

    // Entry: just after a posedge; the current cycle becomes cycle 0.
    // abort_at (1..w) drops valid in that BUSY cycle; keep_valid leaves
    // valid high into the IDLE cycle after ready. use_lit pins the model.
    task automatic run_op(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                          input logic hi, input logic cl, input int unsigned abort_at,
                          input logic keep_valid, input logic use_lit,
                          input logic [31:0] lit);
        int unsigned start, w, lat;
        logic        cl_eff;
        logic [31:0] exp;
`ifdef P_MUL_CLMUL_EN
        cl_eff = cl;
`else
        cl_eff = 1'b0;
`endif
        start = cyc;
        pw    = p;
        lhs   = a;
        rhs   = b;
        high  = hi;
        clmul = cl;
        valid = 1'b1;
        w     = width_of(p);
        lat   = w + 1;
        exp   = ref_mul(p, a, b, hi, cl_eff);
        if (use_lit) begin
            checks++;
            if (exp !== lit) begin
                errors++;
                $display("FAIL model_pin pw=%b lhs=%h rhs=%h high=%b got=%h exp=%h",
                         p, a, b, hi, exp, lit);
            end
        end
        if (abort_at != 0) begin
            repeat (abort_at) @(posedge g_clk);
            #1 valid = 1'b0;
            @(posedge g_clk);
            #1;
        end else begin
            pend_res = exp;
            pend_cyc = start + lat;
            pend_rdy = 1'b1;
            repeat (lat + 1) @(posedge g_clk);
            #1;
            cur_res  = exp;
            pend_cyc = NEVER;
            pend_rdy = 1'b0;
            if (!keep_valid) valid = 1'b0;
        end
    endtask

    task automatic reset_mid_op(input int unsigned at);
        int unsigned start;
        start = cyc;
        pw    = 5'b00001;
        lhs   = $urandom;
        rhs   = $urandom;
        high  = 1'b0;
        clmul = 1'b0;
        valid = 1'b1;
        repeat (at) @(posedge g_clk);
        #1;
        g_reset  = 1'b1;
        valid    = 1'b0;
        pend_res = '0;
        pend_cyc = start + at + 1;
        pend_rdy = 1'b0;
        @(posedge g_clk);
        #1;
        g_reset  = 1'b0;
        cur_res  = '0;
        pend_cyc = NEVER;
    endtask

    initial begin
        logic [4:0]  p;
        logic [31:0] a, b;
        logic        hi, cl, keep, prev_keep;
        int unsigned w, ab;

        g_reset = 1'b1;
        valid   = 1'b0;
        lhs     = '0;
        rhs     = '0;
        pw      = '0;
        high    = 1'b0;
        clmul   = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 chk_en = 1'b1;
        @(posedge g_clk);
        #1 g_reset = 1'b0;
        @(posedge g_clk);
        #1;

        run_op(5'b00001, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0000);
        run_op(5'b00001, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0001);
        run_op(5'b00010, 32'hFFFF_0003, 32'h0002_0005, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'hFFFE_000F);
        run_op(5'b00010, 32'hFFFF_0003, 32'h0002_0005, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h0001_0000);
        run_op(5'b00100, 32'h10FF_0203, 32'h10FF_0405, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h0001_080F);
        run_op(5'b00100, 32'h10FF_0203, 32'h10FF_0405, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h01FE_0000);
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h5555_5555);
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'hAAAA_AAAA);
`ifdef P_MUL_CLMUL_EN
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h5555_5555);
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h5555_5555);
`endif
        // pw=0 completes in one cycle with a zero result; multi-bit pw
        // takes the lowest set bit (here w=4: 0x7*0x3=0x15 per nibble).
        run_op(5'b00000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0000);
        run_op(5'b11000, 32'h7777_7777, 32'h3333_3333, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h5555_5555);
        run_op(5'b11000, 32'h7777_7777, 32'h3333_3333, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h1111_1111);

        // Abort a 32-bit operation, then a normal 8-bit request.
        run_op(5'b00001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 5, 1'b0, 1'b0, '0);
        run_op(5'b00100, 32'h0303_0303, 32'h0505_0505, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h0F0F_0F0F);

        // Back-to-back: valid stays high into the IDLE cycle after ready.
        run_op(5'b01000, 32'h89AB_CDEF, 32'hFEDC_BA98, 1'b1, 1'b0, 0, 1'b1, 1'b0, '0);
        run_op(5'b01000, 32'h89AB_CDEF, 32'hFEDC_BA98, 1'b1, 1'b0, 0, 1'b0, 1'b0, '0);

        // Reset in cycle 10 of a 32-bit operation, then a normal request.
        reset_mid_op(10);
        run_op(5'b00010, 32'hFFFF_0003, 32'h0002_0005, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'hFFFE_000F);

        prev_keep = 1'b0;
        p = '0; a = '0; b = '0; hi = 1'b0; cl = 1'b0;
        for (int n = 0; n < 150; n++) begin
            if (!prev_keep) begin
                p  = 5'($urandom_range(0, 31));
                a  = $urandom;
                b  = $urandom;
                hi = 1'($urandom_range(0, 1));
                cl = 1'($urandom_range(0, 1));
            end
            w    = width_of(p);
            ab   = (w != 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, w) : 0;
            keep = (ab == 0) && ($urandom_range(0, 3) == 0);
            run_op(p, a, b, hi, cl, ab, keep, 1'b0, '0);
            prev_keep = keep;
        end
        if (prev_keep) begin
            run_op(p, a, b, hi, cl, 0, 1'b0, 1'b0, '0);
        end

        repeat (3) @(posedge g_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
